// File: rtl/sisc_fetch_unit.sv
// SISC fetch datapath: program counter, instruction memory with a side load port,
// instruction register and status register feeding the control FSM.
module sisc_fetch_unit #(
  parameter int unsigned MemAw = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pc_rst_i,
  input  logic             pc_write_i,
  input  logic             pc_sel_i,
  input  logic             br_sel_i,
  input  logic             ir_load_i,
  input  logic [3:0]       stat_in_i,
  input  logic             stat_en_i,
  input  logic             imem_we_i,
  input  logic [MemAw-1:0] imem_addr_i,
  input  logic [31:0]      imem_wdata_i,
  output logic [15:0]      pc_out_o,
  output logic [31:0]      instr_o,
  output logic [3:0]       opcode_o,
  output logic [3:0]       mm_o,
  output logic [15:0]      imm_o,
  output logic [3:0]       stat_o
);

  localparam int unsigned Depth = 2 ** MemAw;

  logic [31:0]      mem_q [Depth];
  logic [15:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [3:0]       stat_q, stat_d;
  logic [MemAw-1:0] rd_addr;
  logic [31:0]      fetch_word;

  // Program image is not reset so it can be preloaded while rst_ni is low.
  always_ff @(posedge clk_i) begin
    if (imem_we_i) begin
      mem_q[imem_addr_i] <= imem_wdata_i;
    end
  end

  assign rd_addr = pc_q[MemAw-1:0];

  // Write-first: a same-edge load to the fetched address is forwarded into IR.
  assign fetch_word = (imem_we_i && (imem_addr_i == rd_addr)) ? imem_wdata_i : mem_q[rd_addr];

  always_comb begin
    pc_d = pc_q;
    if (pc_rst_i) begin
      pc_d = '0;
    end else if (pc_write_i) begin
      if (!pc_sel_i) begin
        pc_d = pc_q + 16'd1;
      end else if (br_sel_i) begin
        pc_d = ir_q[15:0];
      end else begin
        pc_d = pc_q + ir_q[15:0];
      end
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (ir_load_i) begin
      ir_d = fetch_word;
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_en_i) begin
      stat_d = stat_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= '0;
      ir_q   <= '0;
      stat_q <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      stat_q <= stat_d;
    end
  end

  assign pc_out_o = pc_q;
  assign instr_o  = ir_q;
  assign opcode_o = ir_q[31:28];
  assign mm_o     = ir_q[27:24];
  assign imm_o    = ir_q[15:0];
  assign stat_o   = stat_q;

endmodule

// File: doc/sisc_fetch_unit.md
# sisc_fetch_unit

Program-counter, instruction-memory and instruction/status-register block for the SISC computer. It is the datapath end of the control FSM's fetch/branch interface. It consumes pc_rst, pc_write, pc_sel, br_sel and ir_load, and returns the decoded opcode, mm field and latched status flags that the FSM's next-state and output logic depend on. A side load port preloads the program image before and during simulation.

## Interface
- MEM_AW, 8, instruction-memory address width (depth 2^MEM_AW words of 32 bits).
- clk  in  1  system clock; all state updates on rising edge.
- rst_f  in  1  reset, asynchronous, active-low; clears all registers immediately.
- pc_rst  in  1  synchronous PC clear request from control.
- pc_write  in  1  PC update enable.
- pc_sel  in  1  0: PC+1, 1: branch target.
- br_sel  in  1  1: absolute target (imm), 0: relative target (PC+imm).
- ir_load  in  1  load IR from imem[PC].
- stat_in  in  4  ALU status flags (C,N,V,Z order as produced by the ALU).
- stat_en  in  1  latch stat_in into status register.
- imem_we  in  1  program-load write strobe.
- imem_addr  in  MEM_AW  program-load address.
- imem_wdata  in  32  program-load data.
- pc_out  out  16  current PC.
- instr  out  32  current IR contents.
- opcode  out  4  instr[31:28].
- mm  out  4  instr[27:24].
- imm  out  16  instr[15:0].
- stat  out  4  status register.

## Operation
- Registers: PC (16 b), IR (32 b), STAT (4 b), imem array (2^MEM_AW x 32, not reset).
- rst_f low: PC=0, IR=0, STAT=0 asynchronously. Therefore opcode=0 (NOOP), mm=0, imm=0, instr=0 and pc_out=0 while reset is held.
- PC update priority at each edge: pc_rst, then pc_write. No action if neither is asserted.
  - pc_rst=1: PC<=0, regardless of pc_write/pc_sel.
  - pc_write=1, pc_sel=0: PC<=PC+1.
  - pc_write=1, pc_sel=1, br_sel=1: PC<=IR[15:0].
  - pc_write=1, pc_sel=1, br_sel=0: PC<=PC+IR[15:0].
- All PC arithmetic is 16-bit modulo 2^16. The relative offset is effectively two's-complement: 0xFFFF steps back one. 0xFFFF+1 wraps to 0.
- Memory is indexed by PC[MEM_AW-1:0]. Upper PC bits are ignored for access but retained in pc_out.
- ir_load=1: IR<=imem[PC[MEM_AW-1:0]], using the PC value before this edge.
- Simultaneous ir_load and pc_write (the fetch cycle): IR captures imem[old PC] and PC becomes old PC+1 on the same edge.
- ir_load=0: IR holds. A branch in decode uses the IR loaded in fetch and the already-incremented PC, so relative targets are PC_of_branch+1+imm.
- imem_we=1: imem[imem_addr]<=imem_wdata at the edge.
  - Same-edge write and ir_load to the same address: IR gets imem_wdata (write-first).
  - Writes are accepted during reset.
- stat_en=1: STAT<=stat_in. Otherwise STAT holds. pc_rst does not affect STAT or IR.
- opcode, mm, imm and instr are pure combinational slices of IR. pc_out and stat drive directly from their registers.

## Timing
- Outputs change only after a rising clk edge or on the falling edge of rst_f. No combinational path from any input to any output.
- ir_load at edge N: opcode/mm/imm are valid after edge N and stable until the next ir_load edge.
- pc_write at edge N: pc_out is updated after edge N.
- One-cycle latency for every register update. No stalls, no handshake beyond the strobes.
- rst_f deassertion mid-cycle: registers stay at reset values until the first rising edge with rst_f high.
- rst_f asserted mid-fetch: PC/IR/STAT clear immediately. A concurrent imem_we still commits at its edge.

## Test plan
- Reset: preload imem[0]=0x1800_0005; hold rst_f low, pulse clk -> pc_out=0, instr=0, stat=0. Release, one fetch (ir_load=1, pc_write=1) -> instr=0x1800_0005, opcode=1, mm=8, imm=5, pc_out=1.
- Absolute branch: IR imm=0x0040, pc_write=1, pc_sel=1, br_sel=1 -> pc_out=0x0040. Next fetch reads imem[0x40].
- Relative branch with wrap: PC=0x0003, imm=0xFFFE, br_sel=0 -> pc_out=0x0001. PC=0xFFFF with pc_sel=0 -> pc_out=0x0000.
- Priority: pc_rst=1 with pc_write=1, pc_sel=1 and PC=0x0010 -> pc_out=0. IR and STAT unchanged.
- Write-first collision: PC=2, same edge imem_we=1, imem_addr=2, wdata=0x4F00_0007, ir_load=1 -> instr=0x4F00_0007.
- Status: stat_en=1, stat_in=4'b0101 -> stat=0101. stat_en=0 with stat_in=1111 -> stat stays 0101. Async rst_f low mid-cycle -> stat=0 before the next edge.
